// File: rtl/alu_datapath_if.sv
// Bus bundle for the ALU datapath: instruction/operand bus, capture and
// output strobes from the controller, and the result, flags and status
// returned by the datapath.
interface alu_datapath_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      fullBitNum;
  logic [15:0]      bus_in;
  logic             ALUin1;
  logic             ALUin2;
  logic             ALU_outlach;
  logic             ALU_outEN;
  logic [15:0]      ALU_out;
  logic             zf;
  logic             cf;
  logic             nf;
  logic             vf;
  logic             res_valid;
  logic             err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output fullBitNum, bus_in, ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    input  ALU_out, zf, cf, nf, vf, res_valid, err, op_count
  );

  modport slave (
    input  fullBitNum, bus_in, ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    output ALU_out, zf, cf, nf, vf, res_valid, err, op_count
  );
endinterface

// File: rtl/alu_datapath.sv
// ALU datapath: captures operand A with the opcode, then operand B, then
// computes and latches a 16-bit result with zero/carry/negative/overflow
// flags. A small sequencing FSM rejects out-of-order or overlapping strobes
// and raises a sticky error. The result drives the bus only when enabled.
module alu_datapath #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  alu_datapath_if.slave bus
);

  typedef enum logic [1:0] {IDLE, A_LD, B_LD, RES} state_t;

  state_t state, next_state;

  logic               cap_a, cap_b, do_latch, set_err;
  logic [1:0]         n_strobe;

  logic signed [15:0] a_p0;
  logic signed [15:0] b_p0;
  logic [3:0]         op_p0;
  logic [15:0]        result_p1;
  logic               zf_p1, cf_p1, nf_p1, vf_p1;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_p1;

  logic [17:0]        eval;
  logic [15:0]        eval_r;
  logic               eval_c, eval_v;
  logic               op_ok;

  // Returns {carry, overflow, result}; undefined opcodes yield all zeros.
  function automatic logic [17:0] alu_eval(input logic [3:0] op,
                                           input logic signed [15:0] a,
                                           input logic signed [15:0] b);
    logic [16:0] sum;
    logic [15:0] r;
    logic        c;
    logic        v;
    logic [31:0] sh;
    r   = 16'h0000;
    c   = 1'b0;
    v   = 1'b0;
    sum = 17'h0;
    sh  = 32'h0;
    case (op)
      4'b1001: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[15:0];
        c   = sum[16];
        v   = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b1010: begin
        r = a - b;
        c = $unsigned(a) < $unsigned(b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b1011: r = a & b;
      4'b1100: r = a | b;
      4'b1101: r = a ^ b;
      4'b1110: begin
        // The last bit pushed out of the top lands at bit 16 of the
        // widened word; a zero shift leaves it clear.
        sh = {16'h0000, a} << b[3:0];
        r  = sh[15:0];
        c  = sh[16];
      end
      4'b1111: begin
        // Mirror image: the last bit pushed out of the bottom lands at bit 15.
        sh = {a, 16'h0000} >> b[3:0];
        r  = sh[31:16];
        c  = sh[15];
      end
      default: begin
        r = 16'h0000;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
    return {c, v, r};
  endfunction

  assign eval   = alu_eval(op_p0, a_p0, b_p0);
  assign eval_c = eval[17];
  assign eval_v = eval[16];
  assign eval_r = eval[15:0];
  assign op_ok  = (op_p0 >= 4'b1001);

  assign n_strobe = {1'b0, bus.ALUin1} + {1'b0, bus.ALUin2} + {1'b0, bus.ALU_outlach};

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and per-cycle control decode; overlapping strobes only flag an error.
  always_comb begin
    next_state = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    do_latch   = 1'b0;
    set_err    = 1'b0;
    if (n_strobe >= 2'd2) begin
      set_err = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ALUin1) begin
            cap_a      = 1'b1;
            next_state = A_LD;
          end else if (bus.ALUin2 || bus.ALU_outlach) begin
            set_err = 1'b1;
          end
        end
        A_LD: begin
          if (bus.ALUin1) begin
            cap_a = 1'b1;
          end else if (bus.ALUin2) begin
            cap_b      = 1'b1;
            next_state = B_LD;
          end else if (bus.ALU_outlach) begin
            set_err = 1'b1;
          end
        end
        B_LD: begin
          if (bus.ALUin2) begin
            cap_b = 1'b1;
          end else if (bus.ALU_outlach) begin
            do_latch   = 1'b1;
            next_state = RES;
          end else if (bus.ALUin1) begin
            set_err    = 1'b1;
            cap_a      = 1'b1;
            next_state = A_LD;
          end
        end
        RES: begin
          if (bus.ALUin1) begin
            cap_a      = 1'b1;
            next_state = A_LD;
          end else if (bus.ALUin2 || bus.ALU_outlach) begin
            set_err = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: operand capture, result/flag latch, counter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= '0;
      result_p1 <= '0;
      zf_p1     <= 1'b0;
      cf_p1     <= 1'b0;
      nf_p1     <= 1'b0;
      vf_p1     <= 1'b0;
      cnt_p1    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (cap_a) begin
        a_p0  <= bus.bus_in;
        op_p0 <= bus.fullBitNum[15:12];
      end
      if (cap_b) b_p0 <= bus.bus_in;
      if (do_latch) begin
        result_p1 <= eval_r;
        zf_p1     <= (eval_r == 16'h0000);
        cf_p1     <= eval_c;
        nf_p1     <= eval_r[15];
        vf_p1     <= eval_v;
        cnt_p1    <= cnt_p1 + CNT_W'(1);
      end
      if (set_err || (do_latch && !op_ok)) err_q <= 1'b1;
    end
  end

  assign bus.ALU_out   = bus.ALU_outEN ? result_p1 : 16'h0000;
  assign bus.zf        = zf_p1;
  assign bus.cf        = cf_p1;
  assign bus.nf        = nf_p1;
  assign bus.vf        = vf_p1;
  assign bus.res_valid = (state == RES);
  assign bus.err       = err_q;
  assign bus.op_count  = cnt_p1;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: arithmetic, logic and shift results with
// flags, sequencing errors, counter wrap and reset behaviour.
module tb_alu_datapath;

  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_datapath_if #(.CNT_W(CNT_W)) bus ();

  alu_datapath #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flags packed as {zf, cf, nf, vf}.
  function automatic logic [31:0] flags();
    return {28'h0, bus.zf, bus.cf, bus.nf, bus.vf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ALUin1      = 1'b0;
    bus.ALUin2      = 1'b0;
    bus.ALU_outlach = 1'b0;
  endtask

  task automatic load_a(input logic [3:0] op, input logic [15:0] v);
    bus.fullBitNum = {op, 12'h000};
    bus.bus_in     = v;
    bus.ALUin1     = 1'b1;
    tick();
  endtask

  task automatic load_b(input logic [15:0] v);
    bus.bus_in = v;
    bus.ALUin2 = 1'b1;
    tick();
  endtask

  task automatic latch();
    bus.ALU_outlach = 1'b1;
    tick();
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    load_a(op, a);
    load_b(b);
    latch();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.fullBitNum  = 16'h0000;
    bus.bus_in      = 16'h0000;
    bus.ALUin1      = 1'b0;
    bus.ALUin2      = 1'b0;
    bus.ALU_outlach = 1'b0;
    bus.ALU_outEN   = 1'b1;
    do_reset();

    chk("rst_out",   bus.ALU_out, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_valid", bus.res_valid, 32'h0);
    chk("rst_err",   bus.err, 32'h0);
    chk("rst_cnt",   bus.op_count, 32'h0);

    // Signed overflow on ADD.
    run_op(4'b1001, 16'h7FFF, 16'h0001);
    chk("add_out",   bus.ALU_out, 32'h8000);
    chk("add_flags", flags(), 32'h3);
    chk("add_cnt",   bus.op_count, 32'd1);
    chk("add_valid", bus.res_valid, 32'h1);
    chk("add_err",   bus.err, 32'h0);
    bus.ALU_outEN = 1'b0;
    #1;
    chk("outen_off", bus.ALU_out, 32'h0);
    bus.ALU_outEN = 1'b1;
    #1;
    chk("outen_on",  bus.ALU_out, 32'h8000);

    // A_LD entered from RES; valid drops immediately.
    load_a(4'b1010, 16'h0003);
    chk("res_to_a_valid", bus.res_valid, 32'h0);
    load_b(16'h0005);
    latch();
    chk("sub_out",   bus.ALU_out, 32'hFFFE);
    chk("sub_flags", flags(), 32'h6);
    chk("sub_cnt",   bus.op_count, 32'd2);
    chk("sub_err",   bus.err, 32'h0);

    run_op(4'b1010, 16'h8000, 16'h0001);
    chk("subv_out",   bus.ALU_out, 32'h7FFF);
    chk("subv_flags", flags(), 32'h1);

    run_op(4'b1111, 16'h0003, 16'h0001);
    chk("shr1_out",   bus.ALU_out, 32'h0001);
    chk("shr1_flags", flags(), 32'h4);
    run_op(4'b1111, 16'h0003, 16'h0000);
    chk("shr0_out",   bus.ALU_out, 32'h0003);
    chk("shr0_flags", flags(), 32'h0);

    run_op(4'b1110, 16'h8001, 16'h0001);
    chk("shl_out",   bus.ALU_out, 32'h0002);
    chk("shl_flags", flags(), 32'h4);
    run_op(4'b1110, 16'h0001, 16'h000F);
    chk("shl15_out",   bus.ALU_out, 32'h8000);
    chk("shl15_flags", flags(), 32'h2);

    run_op(4'b1011, 16'hFF0F, 16'h0FFF);
    chk("and_out", bus.ALU_out, 32'h0F0F);
    run_op(4'b1100, 16'hF000, 16'h000F);
    chk("or_out",   bus.ALU_out, 32'hF00F);
    chk("or_flags", flags(), 32'h2);
    run_op(4'b1101, 16'hA5A5, 16'hA5A5);
    chk("xor_out",   bus.ALU_out, 32'h0000);
    chk("xor_flags", flags(), 32'h8);

    run_op(4'b1001, 16'hFFFF, 16'h0001);
    chk("addc_out",   bus.ALU_out, 32'h0000);
    chk("addc_flags", flags(), 32'hC);
    chk("addc_cnt",   bus.op_count, 32'd11);
    chk("addc_err",   bus.err, 32'h0);

    // Strobes in RES other than ALUin1 leave result and count alone.
    load_b(16'h1234);
    chk("res_b_err", bus.err, 32'h1);
    latch();
    chk("res_l_out", bus.ALU_out, 32'h0000);
    chk("res_l_cnt", bus.op_count, 32'd11);

    // Undefined opcode still latches and counts.
    run_op(4'b0000, 16'h1234, 16'h5678);
    chk("bad_out",   bus.ALU_out, 32'h0);
    chk("bad_flags", flags(), 32'h8);
    chk("bad_cnt",   bus.op_count, 32'd12);
    chk("bad_valid", bus.res_valid, 32'h1);

    // Latch strobe in IDLE.
    do_reset();
    chk("rst2_err", bus.err, 32'h0);
    latch();
    chk("idle_l_err",   bus.err, 32'h1);
    chk("idle_l_valid", bus.res_valid, 32'h0);
    chk("idle_l_cnt",   bus.op_count, 32'h0);

    // Overlapping strobes in A_LD: no capture, still A_LD.
    do_reset();
    load_a(4'b1001, 16'h0005);
    bus.fullBitNum = 16'hA000;
    bus.bus_in     = 16'h0100;
    bus.ALUin1     = 1'b1;
    bus.ALUin2     = 1'b1;
    tick();
    chk("dual_err", bus.err, 32'h1);
    load_b(16'h0001);
    latch();
    chk("dual_out",   bus.ALU_out, 32'h0006);
    chk("dual_valid", bus.res_valid, 32'h1);

    // ALUin1 in B_LD: error, recapture A and continue from A_LD.
    do_reset();
    load_a(4'b1001, 16'h0001);
    load_b(16'h0002);
    load_a(4'b1010, 16'h0010);
    chk("b_a_err", bus.err, 32'h1);
    load_b(16'h0003);
    latch();
    chk("b_a_out", bus.ALU_out, 32'h000D);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) run_op(4'b1001, 16'(i), 16'h0001);
    chk("cnt_255", bus.op_count, 32'd255);
    chk("out_255", bus.ALU_out, 32'd255);
    run_op(4'b1001, 16'h0000, 16'h0000);
    chk("cnt_wrap",  bus.op_count, 32'd0);
    chk("wrap_err",  bus.err, 32'h0);

    // Reset while in B_LD.
    load_a(4'b1001, 16'h4000);
    load_b(16'h4000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("bld_rst_out",   bus.ALU_out, 32'h0);
    chk("bld_rst_flags", flags(), 32'h0);
    chk("bld_rst_valid", bus.res_valid, 32'h0);
    chk("bld_rst_err",   bus.err, 32'h0);
    chk("bld_rst_cnt",   bus.op_count, 32'h0);
    latch();
    chk("bld_rst_idle_err", bus.err, 32'h1);
    chk("bld_rst_idle_cnt", bus.op_count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
